// File: rtl/sha_pkg.sv
// Shared SHA-2 constants: small-sigma rotate/shift amounts for SHA-256 and
// SHA-512, default round counts and the message-schedule FSM state type.
package sha_pkg;

  // SHA-256 small sigma amounts (32-bit words)
  localparam int SHA256_S0_R1 = 7;
  localparam int SHA256_S0_R2 = 18;
  localparam int SHA256_S0_SH = 3;
  localparam int SHA256_S1_R1 = 17;
  localparam int SHA256_S1_R2 = 19;
  localparam int SHA256_S1_SH = 10;

  // SHA-512 small sigma amounts (64-bit words)
  localparam int SHA512_S0_R1 = 1;
  localparam int SHA512_S0_R2 = 8;
  localparam int SHA512_S0_SH = 7;
  localparam int SHA512_S1_R1 = 19;
  localparam int SHA512_S1_R2 = 61;
  localparam int SHA512_S1_SH = 6;

  // Words emitted per block for each variant
  localparam int SHA256_NUM_ROUNDS = 64;
  localparam int SHA512_NUM_ROUNDS = 80;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Select a sigma amount: sel 0 = sigma0, 1 = sigma1;
  // which 0 = first rotate, 1 = second rotate, 2 = shift.
  function automatic int sigma_amt(input int word_w, input int sel, input int which);
    int amt;
    amt = 0;
    if (word_w == 64) begin
      if (sel == 0) begin
        amt = (which == 0) ? SHA512_S0_R1 : (which == 1) ? SHA512_S0_R2 : SHA512_S0_SH;
      end else begin
        amt = (which == 0) ? SHA512_S1_R1 : (which == 1) ? SHA512_S1_R2 : SHA512_S1_SH;
      end
    end else begin
      if (sel == 0) begin
        amt = (which == 0) ? SHA256_S0_R1 : (which == 1) ? SHA256_S0_R2 : SHA256_S0_SH;
      end else begin
        amt = (which == 0) ? SHA256_S1_R1 : (which == 1) ? SHA256_S1_R2 : SHA256_S1_SH;
      end
    end
    return amt;
  endfunction

endpackage

// File: rtl/sha_msg_schedule_if.sv
// Block-in / word-out handshake bundle of the SHA-2 message schedule.
// slave = schedule side, master = block producer / word consumer side.
interface sha_msg_schedule_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 7
);
  logic [16*WORD_W-1:0] blk_in;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [WORD_W-1:0]    w_out;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_valid;
  logic                 w_ready;
  logic                 w_last;

  modport slave (
    input  blk_in, blk_valid, w_ready,
    output blk_ready, w_out, w_idx, w_valid, w_last
  );

  modport master (
    output blk_in, blk_valid, w_ready,
    input  blk_ready, w_out, w_idx, w_valid, w_last
  );
endinterface

// File: rtl/sha_sigma_small.sv
// Combinational SHA-2 small sigma: SEL=0 gives sigma0, SEL=1 gives sigma1.
// Rotate/shift amounts follow WORD_W (32 -> SHA-256, 64 -> SHA-512).
module sha_sigma_small
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEL    = 0
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  localparam int R1 = sigma_amt(WORD_W, SEL, 0);
  localparam int R2 = sigma_amt(WORD_W, SEL, 1);
  localparam int SH = sigma_amt(WORD_W, SEL, 2);

  logic [WORD_W-1:0] rot1_s;
  logic [WORD_W-1:0] rot2_s;
  logic [WORD_W-1:0] shr_s;

  assign rot1_s = {x_i[R1-1:0], x_i[WORD_W-1:R1]};
  assign rot2_s = {x_i[R2-1:0], x_i[WORD_W-1:R2]};
  assign shr_s  = x_i >> SH;
  assign y_o    = rot1_s ^ rot2_s ^ shr_s;

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-2 message-schedule expander. Takes one 16-word block, then streams
// W[0..NUM_ROUNDS-1] one word per accepted beat from a 16-entry circular
// window (slot t mod 16 holds W[t]).
// Optional build macro MSG_BSWAP_EN: byte-reverse each word on load.
module sha_msg_schedule
  import sha_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = SHA256_NUM_ROUNDS,
  parameter int IDX_W      = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  sha_msg_schedule_if.slave bus
);

  // Elaboration-time parameter legality
  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("sha_msg_schedule: WORD_W must be 32 or 64");
  end
  if (NUM_ROUNDS < 16) begin : g_bad_rounds
    $error("sha_msg_schedule: NUM_ROUNDS must be >= 16");
  end
  if ((2 ** IDX_W) < NUM_ROUNDS) begin : g_bad_idx_w
    $error("sha_msg_schedule: IDX_W too narrow for NUM_ROUNDS");
  end

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W-1:0] FIRST_EXP = IDX_W'(16);

`ifdef MSG_BSWAP_EN
  function automatic logic [WORD_W-1:0] bswap(input logic [WORD_W-1:0] x);
    logic [WORD_W-1:0] y;
    y = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      y[b*8 +: 8] = x[WORD_W-8-b*8 +: 8];
    end
    return y;
  endfunction
`endif

  state_e            state_q, state_d;
  logic [WORD_W-1:0] window_q [16];
  logic [IDX_W-1:0]  t_q, t_d;
  logic [WORD_W-1:0] w_out_q, w_out_d;
  logic              w_valid_q, w_valid_d;
  logic              w_last_q, w_last_d;
  logic              blk_ready_q, blk_ready_d;

  logic [WORD_W-1:0] load_word_s [16];
  logic              load_s;
  logic              adv_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  t_nxt_s;
  logic [3:0]        nxt_ptr_s;
  logic [3:0]        ptr_m2_s;
  logic [3:0]        ptr_m7_s;
  logic [3:0]        ptr_m15_s;
  logic [WORD_W-1:0] sig0_s;
  logic [WORD_W-1:0] sig1_s;
  logic [WORD_W-1:0] expand_s;
  logic [WORD_W-1:0] new_word_s;

  // Split the block into words, big-endian word order (word 0 in the MSBs)
  always_comb begin
    for (int i = 0; i < 16; i++) begin
`ifdef MSG_BSWAP_EN
      load_word_s[i] = bswap(bus.blk_in[(16-i)*WORD_W-1 -: WORD_W]);
`else
      load_word_s[i] = bus.blk_in[(16-i)*WORD_W-1 -: WORD_W];
`endif
    end
  end

  // Window slots of W[n-2], W[n-7], W[n-15], W[n-16] for the next word n
  assign t_nxt_s   = t_q + IDX_W'(1);
  assign nxt_ptr_s = t_q[3:0] + 4'd1;
  assign ptr_m2_s  = nxt_ptr_s + 4'd14;
  assign ptr_m7_s  = nxt_ptr_s + 4'd9;
  assign ptr_m15_s = nxt_ptr_s + 4'd1;

  sha_sigma_small #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (
    .x_i (window_q[ptr_m15_s]),
    .y_o (sig0_s)
  );

  sha_sigma_small #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (
    .x_i (window_q[ptr_m2_s]),
    .y_o (sig1_s)
  );

  // Recurrence sum, carry out of WORD_W discarded
  assign expand_s   = sig1_s + window_q[ptr_m7_s] + sig0_s + window_q[nxt_ptr_s];
  assign new_word_s = (t_nxt_s < FIRST_EXP) ? window_q[nxt_ptr_s] : expand_s;

  assign adv_s   = (state_q == EMIT) && bus.w_ready;
  assign wr_en_s = adv_s && (t_q != LAST_IDX) && (t_nxt_s >= FIRST_EXP);

  // Next-state and next-output logic of the IDLE/EMIT controller
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    w_out_d     = w_out_q;
    w_valid_d   = w_valid_q;
    w_last_d    = w_last_q;
    blk_ready_d = blk_ready_q;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.blk_valid) begin
          load_s      = 1'b1;
          state_d     = EMIT;
          t_d         = '0;
          w_out_d     = load_word_s[0];
          w_valid_d   = 1'b1;
          w_last_d    = 1'b0;
          blk_ready_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (adv_s) begin
          if (t_q == LAST_IDX) begin
            state_d     = IDLE;
            w_valid_d   = 1'b0;
            w_last_d    = 1'b0;
            blk_ready_d = 1'b1;
          end else begin
            t_d      = t_nxt_s;
            w_out_d  = new_word_s;
            w_last_d = (t_nxt_s == LAST_IDX);
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d     = IDLE;
        w_valid_d   = 1'b0;
        w_last_d    = 1'b0;
        blk_ready_d = 1'b1;
      end
    endcase
  end

  // Controller and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      w_out_q     <= '0;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
      blk_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      w_out_q     <= w_out_d;
      w_valid_q   <= w_valid_d;
      w_last_q    <= w_last_d;
      blk_ready_q <= blk_ready_d;
    end
  end

  // Circular window: bulk load on block accept, one slot per expanded word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        window_q[i] <= '0;
      end
    end else if (load_s) begin
      for (int i = 0; i < 16; i++) begin
        window_q[i] <= load_word_s[i];
      end
    end else if (wr_en_s) begin
      window_q[nxt_ptr_s] <= new_word_s;
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.w_out     = w_out_q;
  assign bus.w_idx     = t_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.w_last    = w_last_q;

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: SHA-256 and SHA-512 instances,
// table of hand-computed schedule words plus an independent reference
// schedule (direct W[t] recurrence over a flat array).
module tb_sha_msg_schedule;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sha_msg_schedule_if #(.WORD_W(32), .IDX_W(7)) bus32 ();
  sha_msg_schedule_if #(.WORD_W(64), .IDX_W(7)) bus64 ();

  sha_msg_schedule #(.WORD_W(32), .NUM_ROUNDS(64), .IDX_W(7)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  sha_msg_schedule #(.WORD_W(64), .NUM_ROUNDS(80), .IDX_W(7)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64.slave)
  );

  typedef struct {
    bit          is64;
    int          idx;
    logic [63:0] w;
  } vec_t;

  vec_t        vecs [12];
  int          tests = 0;
  int          fails = 0;
  logic [63:0] blk_words [16];
  logic [63:0] ref_w [80];
  logic [63:0] got_w [80];
  int          got_idx [80];
  logic        got_last [80];
  int          n_got;
  int          n_cycles;
  logic [63:0] bswap_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int w, input int r);
    logic [63:0] v;
    v = x & msk(w);
    return ((v >> r) | (v << (w - r))) & msk(w);
  endfunction

  function automatic logic [63:0] sig(input logic [63:0] x, input int w, input int sel);
    logic [63:0] v;
    v = x & msk(w);
    if (w == 32) begin
      if (sel == 0) return rotr(v, 32, 7) ^ rotr(v, 32, 18) ^ (v >> 3);
      else          return rotr(v, 32, 17) ^ rotr(v, 32, 19) ^ (v >> 10);
    end else begin
      if (sel == 0) return rotr(v, 64, 1) ^ rotr(v, 64, 8) ^ (v >> 7);
      else          return rotr(v, 64, 19) ^ rotr(v, 64, 61) ^ (v >> 6);
    end
  endfunction

  task automatic build_ref(input int w, input int n);
    for (int t = 0; t < n; t++) begin
      if (t < 16) ref_w[t] = blk_words[t] & msk(w);
      else ref_w[t] = (sig(ref_w[t-2], w, 1) + ref_w[t-7] + sig(ref_w[t-15], w, 0)
                       + ref_w[t-16]) & msk(w);
    end
  endtask

  task automatic set_abc(input int w);
    for (int i = 0; i < 16; i++) blk_words[i] = 64'h0;
    blk_words[0]  = (w == 64) ? 64'h6162_6380_0000_0000 : 64'h0000_0000_6162_6380;
    blk_words[15] = 64'h0000_0000_0000_0018;
  endtask

  task automatic load32();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus32.blk_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("load32_ready", 64'(bus32.blk_ready), 64'h1);
    for (int i = 0; i < 16; i++) bus32.blk_in[(16-i)*32-1 -: 32] = blk_words[i][31:0];
    bus32.blk_valid = 1'b1;
    @(negedge clk);
    bus32.blk_valid = 1'b0;
    check("first_word_latency_valid", 64'(bus32.w_valid), 64'h1);
    check("first_word_latency_idx", 64'(bus32.w_idx), 64'h0);
  endtask

  // mode 0: w_ready held high; mode 1: pseudo-random w_ready.
  // stop_at >= 0 returns when that index is presented (not accepted).
  task automatic collect32(input int mode, input int stop_at, input bit noise);
    bit          stalled;
    bit          rdy;
    logic [31:0] p_out;
    logic [6:0]  p_idx;
    n_got    = 0;
    n_cycles = 0;
    stalled  = 1'b0;
    p_out    = 32'h0;
    p_idx    = 7'h0;
    while (n_got < 64 && n_cycles < 400) begin
      if (stalled) begin
        check("stall_out", 64'(bus32.w_out), 64'(p_out));
        check("stall_idx", 64'(bus32.w_idx), 64'(p_idx));
        check("stall_valid", 64'(bus32.w_valid), 64'h1);
      end
      if (stop_at >= 0 && bus32.w_valid && int'(bus32.w_idx) == stop_at) return;
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus32.w_ready   = rdy;
      bus32.blk_valid = noise && (n_cycles < 10);
      if (bus32.w_valid && rdy) begin
        got_w[n_got]    = 64'(bus32.w_out);
        got_idx[n_got]  = int'(bus32.w_idx);
        got_last[n_got] = bus32.w_last;
        n_got++;
      end
      stalled = bus32.w_valid && !rdy;
      p_out   = bus32.w_out;
      p_idx   = bus32.w_idx;
      n_cycles++;
      @(negedge clk);
    end
    bus32.blk_valid = 1'b0;
    if (n_got < 64) check("collect32_timeout", 64'(n_got), 64'd64);
  endtask

  task automatic check_seq(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", tag, i), got_w[i], ref_w[i]);
      check($sformatf("%s_idx%0d", tag, i), 64'(got_idx[i]), 64'(i));
      check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
    end
  endtask

  task automatic check_table(input bit is64);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is64 == is64) begin
        check($sformatf("vec%0d_w%0d", i, vecs[i].idx), got_w[vecs[i].idx], vecs[i].w);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 0,  64'h0000_0000_6162_6380};
    vecs[1]  = '{1'b0, 1,  64'h0000_0000_0000_0000};
    vecs[2]  = '{1'b0, 15, 64'h0000_0000_0000_0018};
    vecs[3]  = '{1'b0, 16, 64'h0000_0000_6162_6380};
    vecs[4]  = '{1'b0, 17, 64'h0000_0000_000F_0000};
    vecs[5]  = '{1'b0, 18, 64'h0000_0000_7DA8_6405};
    vecs[6]  = '{1'b0, 19, 64'h0000_0000_6000_03C6};
    vecs[7]  = '{1'b0, 63, 64'h0000_0000_12B1_EDEB};
    vecs[8]  = '{1'b1, 0,  64'h6162_6380_0000_0000};
    vecs[9]  = '{1'b1, 15, 64'h0000_0000_0000_0018};
    vecs[10] = '{1'b1, 16, 64'h6162_6380_0000_0000};
    vecs[11] = '{1'b1, 17, 64'h0003_0000_0000_00C0};

    rst_n           = 1'b0;
    bus32.blk_in    = '0;
    bus32.blk_valid = 1'b0;
    bus32.w_ready   = 1'b0;
    bus64.blk_in    = '0;
    bus64.blk_valid = 1'b0;
    bus64.w_ready   = 1'b0;

    // Reset state
    #12;
    check("rst_blk_ready", 64'(bus32.blk_ready), 64'h1);
    check("rst_w_valid", 64'(bus32.w_valid), 64'h0);
    check("rst_w_last", 64'(bus32.w_last), 64'h0);
    check("rst_w_idx", 64'(bus32.w_idx), 64'h0);
    check("rst_w_out", 64'(bus32.w_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" block, continuous w_ready
    set_abc(32);
    build_ref(32, 64);
    load32();
    collect32(0, -1, 1'b0);
    check("abc_cycles", 64'(n_cycles), 64'd64);
    check_seq("abc", 64);
    check_table(1'b0);

    // "abc" block, pseudo-random w_ready with stall stability checks
    load32();
    collect32(1, -1, 1'b0);
    check_seq("abc_rnd", 64);

    // All-zero block with an ignored block offered during EMIT
    for (int i = 0; i < 16; i++) blk_words[i] = 64'h0;
    build_ref(32, 64);
    load32();
    bus32.blk_in = {16{32'hDEAD_BEEF}};
    collect32(0, -1, 1'b1);
    check_seq("zero", 64);
    check("zero_ready_after_last", 64'(bus32.blk_ready), 64'h1);
    check("zero_valid_after_last", 64'(bus32.w_valid), 64'h0);

    // Asynchronous reset in the middle of a block
    set_abc(32);
    build_ref(32, 64);
    load32();
    collect32(0, 30, 1'b0);
    check("mid_idx_before_rst", 64'(bus32.w_idx), 64'd30);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_w_valid", 64'(bus32.w_valid), 64'h0);
    check("mid_rst_blk_ready", 64'(bus32.blk_ready), 64'h1);
    check("mid_rst_w_idx", 64'(bus32.w_idx), 64'h0);
    check("mid_rst_w_out", 64'(bus32.w_out), 64'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_w_valid", 64'(bus32.w_valid), 64'h0);
    load32();
    collect32(0, -1, 1'b0);
    check("reload_cycles", 64'(n_cycles), 64'd64);
    check_seq("reload", 64);

    // Little-endian word load
    for (int i = 0; i < 16; i++) blk_words[i] = 64'h0;
    blk_words[0] = 64'h0000_0000_8063_6261;
`ifdef MSG_BSWAP_EN
    bswap_exp = 64'h0000_0000_6162_6380;
`else
    bswap_exp = 64'h0000_0000_8063_6261;
`endif
    load32();
    check("bswap_w0", 64'(bus32.w_out), bswap_exp);
    collect32(0, -1, 1'b0);

    // SHA-512 instance, "abc" block, 80 words
    set_abc(64);
    build_ref(64, 80);
    for (int i = 0; i < 16; i++) bus64.blk_in[(16-i)*64-1 -: 64] = blk_words[i];
    bus64.w_ready = 1'b1;
    @(negedge clk);
    check("s512_ready", 64'(bus64.blk_ready), 64'h1);
    bus64.blk_valid = 1'b1;
    @(negedge clk);
    bus64.blk_valid = 1'b0;
    n_got    = 0;
    n_cycles = 0;
    while (n_got < 80 && n_cycles < 400) begin
      if (bus64.w_valid) begin
        got_w[n_got]    = bus64.w_out;
        got_idx[n_got]  = int'(bus64.w_idx);
        got_last[n_got] = bus64.w_last;
        n_got++;
      end
      n_cycles++;
      @(negedge clk);
    end
    check("s512_count", 64'(n_got), 64'd80);
    check("s512_cycles", 64'(n_cycles), 64'd80);
    check_seq("s512", 80);
    check_table(1'b1);
    check("s512_ready_after_last", 64'(bus64.blk_ready), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
